// File: rtl/if_id_stage.sv
// IF/ID pipeline register with valid/ready handshakes on both sides, a one-entry
// skid buffer so ready_f is state-derived, flush-to-NOP and a saturating stall counter.
module if_id_stage #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]  NOP_INSTR  = 32'h00000013,
  parameter int unsigned            CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_f,
  output logic                  ready_f,
  input  logic [DATA_WIDTH-1:0] RDF,
  input  logic [ADDR_WIDTH-1:0] PCF,
  input  logic [ADDR_WIDTH-1:0] PCPlus4F,
  input  logic                  flush,
  output logic                  valid_d,
  input  logic                  ready_d,
  output logic [DATA_WIDTH-1:0] InstrD,
  output logic [ADDR_WIDTH-1:0] PCD,
  output logic [ADDR_WIDTH-1:0] PCPlus4D,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] main_instr, skid_instr;
  logic [ADDR_WIDTH-1:0] main_pc, main_pc4, skid_pc, skid_pc4;
  logic                  in_fire, out_fire;

  // Handshake flags decode the state register only, so ready_f never sees ready_d.
  assign valid_d  = (state != EMPTY);
  assign ready_f  = (state != SKID);
  assign in_fire  = valid_f & ready_f;
  assign out_fire = valid_d & ready_d;

  assign InstrD   = valid_d ? main_instr : NOP_INSTR;
  assign PCD      = main_pc;
  assign PCPlus4D = main_pc4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      main_instr <= '0;
      main_pc    <= '0;
      main_pc4   <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
      skid_pc4   <= '0;
      stall_cnt  <= '0;
    end else begin
      if (valid_d && !ready_d && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);

      // Flush only retargets the state; main payload stays so PCD/PCPlus4D hold.
      if (flush) begin
        state <= EMPTY;
      end else begin
        case (state)
          EMPTY: begin
            if (in_fire) begin
              main_instr <= RDF;
              main_pc    <= PCF;
              main_pc4   <= PCPlus4F;
              state      <= FULL;
            end
          end
          FULL: begin
            if (in_fire && out_fire) begin
              main_instr <= RDF;
              main_pc    <= PCF;
              main_pc4   <= PCPlus4F;
            end else if (in_fire) begin
              skid_instr <= RDF;
              skid_pc    <= PCF;
              skid_pc4   <= PCPlus4F;
              state      <= SKID;
            end else if (out_fire) begin
              state <= EMPTY;
            end
          end
          SKID: begin
            if (out_fire) begin
              main_instr <= skid_instr;
              main_pc    <= skid_pc;
              main_pc4   <= skid_pc4;
              state      <= FULL;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: the driver queues each accepted entry, the
// monitor pops and compares on every out_fire and checks NOP while idle.
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst, valid_f, ready_f, flush, valid_d, ready_d;
  logic [31:0] RDF, PCF, PCPlus4F, InstrD, PCD, PCPlus4D;
  logic [3:0]  stall_cnt;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } entry_t;

  entry_t exp_q[$];
  int     checks = 0;
  int     errors = 0;
  bit     mon_en = 1'b0;

  if_id_stage #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .NOP_INSTR (32'h00000013),
    .CNT_WIDTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_f  (valid_f),
    .ready_f  (ready_f),
    .RDF      (RDF),
    .PCF      (PCF),
    .PCPlus4F (PCPlus4F),
    .flush    (flush),
    .valid_d  (valid_d),
    .ready_d  (ready_d),
    .InstrD   (InstrD),
    .PCD      (PCD),
    .PCPlus4D (PCPlus4D),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes the scoreboard on each out_fire, checks NOP when idle.
  always @(negedge clk) begin : monitor
    entry_t e;
    if (mon_en) begin
      if (valid_d === 1'b1 && ready_d === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got pc %h expected no entry at %0t", PCD, $time);
        end else begin
          e = exp_q.pop_front();
          chk("InstrD", InstrD, e.instr);
          chk("PCD", PCD, e.pc);
          chk("PCPlus4D", PCPlus4D, e.pc4);
        end
      end else if (valid_d === 1'b0) begin
        chk("InstrD_nop", InstrD, NOP);
      end
    end
  end

  // One clock of stimulus; exp_rf/exp_vd are the hand-derived flags for the current state.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic [31:0] pc4, input logic rd, input logic fl, input logic rs,
                     input logic exp_rf, input logic exp_vd);
    entry_t e;
    valid_f  = v;
    RDF      = ins;
    PCF      = pc;
    PCPlus4F = pc4;
    ready_d  = rd;
    flush    = fl;
    rst      = rs;
    @(negedge clk);
    chk("ready_f", {31'b0, ready_f}, {31'b0, exp_rf});
    chk("valid_d", {31'b0, valid_d}, {31'b0, exp_vd});
    if (v && exp_rf && !fl && !rs) begin
      e.instr = ins;
      e.pc    = pc;
      e.pc4   = pc4;
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (fl || rs) exp_q.delete();
    #1;
  endtask

  initial begin
    rst = 1'b1; valid_f = 1'b0; ready_d = 1'b0; flush = 1'b0;
    RDF = '0; PCF = '0; PCPlus4F = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid_d", {31'b0, valid_d}, 32'd0);
    chk("rst_ready_f", {31'b0, ready_f}, 32'd1);
    chk("rst_InstrD", InstrD, NOP);
    chk("rst_PCD", PCD, 32'd0);
    chk("rst_PCPlus4D", PCPlus4D, 32'd0);
    chk("rst_stall_cnt", {28'b0, stall_cnt}, 32'd0);
    mon_en = 1'b1;

    // 1: streaming, zero bubbles (last entry has a deliberately unusual PC+4 field)
    cyc(1, 32'h00500093, 32'h0, 32'h4,    1, 0, 0, 1, 0);
    cyc(1, 32'h00600113, 32'h4, 32'h8,    1, 0, 0, 1, 1);
    cyc(1, 32'h002081B3, 32'h8, 32'hC,    1, 0, 0, 1, 1);
    cyc(1, 32'h00700213, 32'hC, 32'h1234, 1, 0, 0, 1, 1);
    cyc(0, 32'h0,        32'h0, 32'h0,    1, 0, 0, 1, 1);

    // 2: back-pressure into the skid entry, 0x18 refused until space frees
    cyc(1, 32'h00A00293, 32'h10, 32'h14, 1, 0, 0, 1, 0);
    cyc(1, 32'h00B00313, 32'h14, 32'h18, 0, 0, 0, 1, 1);
    cyc(1, 32'h00C00393, 32'h18, 32'h1C, 0, 0, 0, 0, 1);
    cyc(1, 32'h00C00393, 32'h18, 32'h1C, 0, 0, 0, 0, 1);
    cyc(1, 32'h00C00393, 32'h18, 32'h1C, 1, 0, 0, 0, 1);
    cyc(1, 32'h00C00393, 32'h18, 32'h1C, 1, 0, 0, 1, 1);
    cyc(0, 32'h0,        32'h0,  32'h0,  1, 0, 0, 1, 1);
    chk("stall_cnt_bp", {28'b0, stall_cnt}, 32'd3);

    // 3: flush while in SKID with an incoming fetch
    cyc(1, 32'h00D00413, 32'h20, 32'h24, 0, 0, 0, 1, 0);
    cyc(1, 32'h00E00493, 32'h24, 32'h28, 0, 0, 0, 1, 1);
    cyc(1, 32'h00F00513, 32'h28, 32'h2C, 0, 1, 0, 0, 1);
    chk("flush_valid_d", {31'b0, valid_d}, 32'd0);
    chk("flush_InstrD", InstrD, NOP);
    chk("flush_PCD_hold", PCD, 32'h20);
    chk("flush_PCPlus4D_hold", PCPlus4D, 32'h24);
    chk("stall_cnt_flush", {28'b0, stall_cnt}, 32'd5);
    cyc(0, 32'h0, 32'h0, 32'h0, 1, 0, 0, 1, 0);

    // 4: flush while EMPTY with in_fire drops the fetch
    cyc(1, 32'h01000593, 32'h2C, 32'h30, 1, 1, 0, 1, 0);
    cyc(0, 32'h0,        32'h0,  32'h0,  1, 0, 0, 1, 0);
    chk("flush_empty_PCD", PCD, 32'h20);

    // flush with a same-cycle out_fire: the shown entry is still consumed
    cyc(1, 32'h01100613, 32'h30, 32'h34, 1, 0, 0, 1, 0);
    cyc(1, 32'h01200693, 32'h34, 32'h38, 1, 1, 0, 1, 1);
    cyc(0, 32'h0,        32'h0,  32'h0,  1, 0, 0, 1, 0);

    // 6: counter saturates at 15 (starts from 5 here)
    cyc(1, 32'h01300713, 32'h40, 32'h44, 0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) cyc(0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1, 1);
    chk("stall_cnt_sat", {28'b0, stall_cnt}, 32'd15);

    // 5: reset while in SKID
    cyc(1, 32'h01400793, 32'h44, 32'h48, 0, 0, 0, 1, 1);
    cyc(1, 32'h01500813, 32'h48, 32'h4C, 0, 0, 1, 0, 1);
    chk("mrst_valid_d", {31'b0, valid_d}, 32'd0);
    chk("mrst_ready_f", {31'b0, ready_f}, 32'd1);
    chk("mrst_PCD", PCD, 32'd0);
    chk("mrst_PCPlus4D", PCPlus4D, 32'd0);
    chk("mrst_stall_cnt", {28'b0, stall_cnt}, 32'd0);
    chk("mrst_InstrD", InstrD, NOP);

    // recovery after reset
    cyc(1, 32'h01600893, 32'h50, 32'h54, 1, 0, 0, 1, 0);
    cyc(0, 32'h0,        32'h0,  32'h0,  1, 0, 0, 1, 1);
    cyc(0, 32'h0,        32'h0,  32'h0,  1, 0, 0, 1, 0);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Parametrised IF/ID pipeline register for the pipelined core. It replaces the fixed single-register IF/ID stage.
- Adds a valid/ready handshake toward IF and toward ID.
- Adds a one-entry skid buffer, so IF can be back-pressured with a registered ready.
- Adds a flush that squashes in-flight fetches and drives a NOP into ID.
- Adds a saturating stall-cycle counter for performance monitoring.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 32, PC width.
- NOP_INSTR, 32'h00000013, instruction presented on InstrD when no valid entry is held (addi x0,x0,0).
- CNT_WIDTH, 16, stall-counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- valid_f  in  1  IF presents a fetched instruction.
- ready_f  out  1  stage can accept; driven from state only, no combinational path from ready_d.
- RDF  in  DATA_WIDTH  fetched instruction word.
- PCF  in  ADDR_WIDTH  PC of fetched instruction.
- PCPlus4F  in  ADDR_WIDTH  PC+4 of fetched instruction.
- flush  in  1  squash all held and incoming entries (branch/jump taken in EX).
- valid_d  out  1  InstrD/PCD/PCPlus4D hold a valid entry.
- ready_d  in  1  ID accepts; equals ~StallD from the hazard unit.
- InstrD  out  DATA_WIDTH  instruction to decode.
- PCD  out  ADDR_WIDTH  PC of InstrD.
- PCPlus4D  out  ADDR_WIDTH  PC+4 of InstrD.
- stall_cnt  out  CNT_WIDTH  cycles with valid_d=1 and ready_d=0.

Behaviour:
Fire conditions:
- in_fire = valid_f & ready_f.
- out_fire = valid_d & ready_d.

Storage and datapath:
- Two entries: main (drives outputs) and skid. Each entry holds {instr, pc, pc_plus4}.
- Field mapping is strict: RDF→InstrD, PCF→PCD, PCPlus4F→PCPlus4D. No fields are swapped and no value is recomputed.
- All payload is passed through unchanged; no arithmetic.

States:
- EMPTY: valid_d=0, ready_f=1.
- FULL: valid_d=1, ready_f=1.
- SKID: valid_d=1, ready_f=0.

Transitions (evaluated at the rising edge, when rst=0 and flush=0):
- EMPTY, in_fire: main<=input; go to FULL.
- EMPTY, no in_fire: stay in EMPTY.
- FULL, in_fire & out_fire: main<=input; stay in FULL.
- FULL, in_fire & ~out_fire: skid<=input; go to SKID.
- FULL, ~in_fire & out_fire: go to EMPTY.
- FULL, neither: hold.
- SKID, out_fire: main<=skid; go to FULL. Input is ignored because ready_f=0.
- SKID, ~out_fire: hold both entries.

Latency:
- 1 cycle from in_fire to valid_d, when the stage is EMPTY or FULL with out_fire.
- Zero-bubble throughput when ready_d stays high.

Output rules:
- InstrD = valid_d ? main.instr : NOP_INSTR (combinational mux).
- PCD and PCPlus4D show main.pc and main.pc_plus4; they hold their last value when valid_d=0.

Flush:
- Priority below rst, above all other events.
- At the next edge: state<=EMPTY and skid is discarded.
- A same-cycle in_fire is dropped.
- A same-cycle out_fire still counts as consumed by ID.
- PCD and PCPlus4D hold their values.

Reset (rst=1 at an edge):
- state<=EMPTY, so valid_d=0, ready_f=1 and InstrD=NOP_INSTR.
- Main and skid payload<=0, so PCD=0 and PCPlus4D=0.
- stall_cnt<=0.
- Inputs are ignored.
- Reset overrides flush and any handshake in progress.

stall_cnt:
- Increments by 1 on each edge where valid_d & ~ready_d.
- Saturates at 2^CNT_WIDTH-1.
- Not cleared by flush.

Invariant: skid is valid only in SKID; no entry is ever lost or duplicated absent a flush.

Test Plan:
1. Reset then stream: rst 2 cycles; valid_f=1, ready_d=1; PCF=0x0,0x4,0x8; RDF=0x00500093,0x00600113,0x002081B3 -> one cycle later, back-to-back:
   - InstrD=0x00500093/0x00600113/0x002081B3.
   - PCD=0x0/0x4/0x8.
   - PCPlus4D=0x4/0x8/0xC.
   - valid_d=1 with no bubbles.
2. Back-pressure: stream PCs 0x10 and 0x14, with ready_d=0 from the cycle the 0x10 entry becomes valid:
   - Main holds 0x10 and skid captures 0x14.
   - ready_f=0 the next cycle and input 0x18 is not accepted.
   - When ready_d returns to 1, PCD shows 0x10 then 0x14 then 0x18, in order with no loss.
   - stall_cnt equals the number of ready_d=0 cycles with valid_d=1.
3. Flush in SKID, with valid_f=1 on the same cycle: next cycle valid_d=0, InstrD=0x00000013, ready_f=1, and the incoming entry is dropped.
4. Flush when EMPTY with in_fire: -> valid_d stays 0.
5. Mid-operation reset: assert rst while in SKID -> next cycle valid_d=0, PCD=0, PCPlus4D=0, stall_cnt=0, ready_f=1.
6. Counter saturation (CNT_WIDTH=4): hold valid_d=1, ready_d=0 for 20 cycles -> stall_cnt stops at 15.
